// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   state_t      - arbiter FSM state encoding
//   DEF_*        - default parameter values for dmem_arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NCORES  = 4;
    localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req       in  NCORES  request vector
//   rr_ptr    in  IDXW    index with highest priority this round
//   grant     out NCORES  one-hot grant (all zero when no request)
//   grant_idx out IDXW    index of the granted requester
module rr_arbiter #(
    parameter int NCORES = 4,
    parameter int IDXW   = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IDXW-1:0]   rr_ptr,
    output logic [NCORES-1:0] grant,
    output logic [IDXW-1:0]   grant_idx
);

    int   idx;
    logic found;

    // Walk the cores starting at rr_ptr, wrapping; first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NCORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCORES) idx = idx - NCORES;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DRAM port among NCORES cores, one access at a time.
// Reads from several cores to the same address in the same cycle are merged
// into a single DRAM read; writes are always served one core at a time.
//   Clk, rstn         clock, synchronous active-low reset
//   AR, DR            per-core address / write data, core i at [i*WIDTH +: WIDTH]
//   mread_en_c        per-core read request (level, held until memAV)
//   mwrite_en_c       per-core write request (level, held until memAV)
//   MEM               DRAM read data
//   Addrs, Wdata      DRAM address / write data
//   mread_en/mwrite_en DRAM strobes, high for the single ISSUE cycle
//   MEM_C             per-core read data, held between completions
//   memAV             per-core completion pulse (DONE cycle)
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCORES  = DEF_NCORES,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                     Clk,
    input  logic                     rstn,
    input  logic [NCORES*WIDTH-1:0]  AR,
    input  logic [NCORES*WIDTH-1:0]  DR,
    input  logic [NCORES-1:0]        mread_en_c,
    input  logic [NCORES-1:0]        mwrite_en_c,
    input  logic [WIDTH-1:0]         MEM,
    output logic [WIDTH-1:0]         Addrs,
    output logic [WIDTH-1:0]         Wdata,
    output logic                     mread_en,
    output logic                     mwrite_en,
    output logic [NCORES*WIDTH-1:0]  MEM_C,
    output logic [NCORES-1:0]        memAV
);

    localparam int IDXW = $clog2(NCORES);
    localparam int CW   = $clog2(MEM_LAT + 1);

    state_t state, state_nx;

    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   gidx_q;
    logic [CW-1:0]     cnt;
    logic [NCORES-1:0] grp_q;
    logic              op_wr_q;
    logic [WIDTH-1:0]  addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [NCORES*WIDTH-1:0] mem_c_q;

    logic [NCORES-1:0] req;
    logic [NCORES-1:0] rd_only;
    logic [NCORES-1:0] grant;
    logic [IDXW-1:0]   grant_idx;
    logic [NCORES-1:0] addr_hit;
    logic [NCORES-1:0] grp_nx;
    logic [WIDTH-1:0]  ar_a [NCORES];
    logic [WIDTH-1:0]  dr_a [NCORES];
    logic [WIDTH-1:0]  gaddr;
    logic              g_wr;

    // A core with both strobes up counts as a writer, so it never joins a read group.
    assign req     = mread_en_c | mwrite_en_c;
    assign rd_only = mread_en_c & ~mwrite_en_c;

    rr_arbiter #(
        .NCORES (NCORES),
        .IDXW   (IDXW)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign gaddr = ar_a[grant_idx];
    assign g_wr  = mwrite_en_c[grant_idx];

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        assign ar_a[i]     = AR[i*WIDTH +: WIDTH];
        assign dr_a[i]     = DR[i*WIDTH +: WIDTH];
        assign addr_hit[i] = (ar_a[i] == gaddr);
    end

    // Read group: every read-only requester on the granted address (includes the winner).
    assign grp_nx = g_wr ? grant : (rd_only & addr_hit);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latched request, latency counter, round-robin pointer, read data
    always_ff @(posedge Clk) begin
        if (!rstn) begin
            rr_ptr  <= '0;
            gidx_q  <= '0;
            cnt     <= '0;
            grp_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mem_c_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gidx_q  <= grant_idx;
                        addr_q  <= gaddr;
                        wdata_q <= dr_a[grant_idx];
                        op_wr_q <= g_wr;
                        grp_q   <= grp_nx;
                    end
                end
                ISSUE: cnt <= CW'(MEM_LAT - 1);
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!op_wr_q) begin
                        // last WAIT edge: DRAM data is valid now
                        for (int i = 0; i < NCORES; i++) begin
                            if (grp_q[i]) mem_c_q[i*WIDTH +: WIDTH] <= MEM;
                        end
                    end
                end
                DONE: rr_ptr <= (gidx_q == IDXW'(NCORES - 1)) ? '0 : gidx_q + IDXW'(1);
                default: ;
            endcase
        end
    end

    assign Addrs     = addr_q;
    assign Wdata     = wdata_q;
    assign mread_en  = (state == ISSUE) && !op_wr_q;
    assign mwrite_en = (state == ISSUE) &&  op_wr_q;
    assign memAV     = (state == DONE) ? grp_q : '0;
    assign MEM_C     = mem_c_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int NC  = 4;
    localparam int W   = 8;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NC*W-1:0] ar, dr, memc;
    logic [NC-1:0]   rd_c, wr_c, av;
    logic [W-1:0]    mem, addrs, wdata;
    logic            mrd, mwr;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(W), .NCORES(NC), .MEM_LAT(LAT)) dut (
        .Clk(clk), .rstn(rstn), .AR(ar), .DR(dr),
        .mread_en_c(rd_c), .mwrite_en_c(wr_c), .MEM(mem),
        .Addrs(addrs), .Wdata(wdata), .mread_en(mrd), .mwrite_en(mwr),
        .MEM_C(memc), .memAV(av)
    );

    int total = 0;
    int bad   = 0;
    bit rand_mem = 1'b0;

    // Transaction-level reference: one operation occupies 1 issue cycle,
    // LAT wait cycles, 1 done cycle and 1 return cycle before the next grant.
    int          busy = -1;
    int          ptr  = 0;
    int          g    = 0;
    logic        gwr;
    logic [NC-1:0] grp;
    logic [W-1:0] memc_ref [NC];
    logic        exp_rd, exp_wr;
    logic [W-1:0] exp_addr, exp_wd;
    logic [NC-1:0] exp_av;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!rstn) begin
            busy = -1; ptr = 0; exp_rd = 0; exp_wr = 0;
            exp_addr = '0; exp_wd = '0; exp_av = '0;
            for (int i = 0; i < NC; i++) memc_ref[i] = '0;
        end else if (busy < 0) begin
            exp_av = '0;
            if (|(rd_c | wr_c)) begin
                g = -1;
                for (int k = 0; k < NC; k++) begin
                    int idx;
                    idx = (ptr + k) % NC;
                    if (g < 0 && (rd_c[idx] || wr_c[idx])) g = idx;
                end
                gwr      = wr_c[g];
                exp_addr = ar[g*W +: W];
                exp_wd   = dr[g*W +: W];
                grp      = '0;
                for (int i = 0; i < NC; i++)
                    if (gwr) grp[i] = (i == g);
                    else     grp[i] = rd_c[i] && !wr_c[i] && (ar[i*W +: W] == exp_addr);
                exp_rd = !gwr;
                exp_wr = gwr;
                busy   = 0;
            end
        end else begin
            busy++;
            exp_rd = 0; exp_wr = 0; exp_av = '0;
            if (busy == LAT + 1) begin
                if (!gwr)
                    for (int i = 0; i < NC; i++) if (grp[i]) memc_ref[i] = mem;
                exp_av = grp;
                ptr    = (g + 1) % NC;
            end else if (busy == LAT + 2) begin
                busy = -1;
            end
        end
    endtask

    task automatic check_all();
        logic [NC*W-1:0] em;
        for (int i = 0; i < NC; i++) em[i*W +: W] = memc_ref[i];
        chk("mread_en", mrd, exp_rd);
        chk("mwrite_en", mwr, exp_wr);
        chk("Addrs", addrs, exp_addr);
        chk("Wdata", wdata, exp_wd);
        chk("memAV", av, exp_av);
        chk("MEM_C", memc, em);
    endtask

    // One clock: model follows the edge, outputs are checked mid-cycle,
    // completed cores drop their requests.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        for (int i = 0; i < NC; i++) if (exp_av[i]) begin rd_c[i] = 0; wr_c[i] = 0; end
        if (rand_mem) mem = W'($urandom);
    endtask

    task automatic wait_any(output logic [NC-1:0] got);
        int n;
        n = 0;
        do begin cyc(); n++; end while (av === '0 && n < 20);
        got = av;
        if (n >= 20) chk("timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_av(input string tag, input logic [NC-1:0] exp);
        logic [NC-1:0] got;
        wait_any(got);
        chk(tag, got, exp);
    endtask

    task automatic set_req(input int c, input bit r, input bit w, input logic [W-1:0] a, input logic [W-1:0] d);
        rd_c[c] = r; wr_c[c] = w; ar[c*W +: W] = a; dr[c*W +: W] = d;
    endtask

    initial begin
        logic [NC-1:0] got;
        bit got3;
        int n;
        rstn = 0; rd_c = '0; wr_c = '0; ar = '0; dr = '0; mem = '0;
        cyc(); cyc();
        chk("rst_memc", memc, '0);
        chk("rst_av", av, '0);
        rstn = 1;

        // single read
        mem = 8'hA5;
        set_req(2, 1, 0, 8'h3C, 8'h00);
        cyc();
        chk("rd1_strobe", mrd, 1'b1);
        chk("rd1_addr", addrs, 8'h3C);
        cyc(); cyc(); cyc();
        chk("rd1_av", av, 4'b0100);
        chk("rd1_data", memc[2*W +: W], 8'hA5);
        cyc();

        // coalesced read (pointer sits at core3)
        set_req(0, 1, 0, 8'h10, 0); set_req(1, 1, 0, 8'h10, 0);
        set_req(3, 1, 0, 8'h10, 0); set_req(2, 1, 0, 8'h20, 0);
        wait_av("coal_a", 4'b1011);
        wait_av("coal_b", 4'b0100);
        cyc();

        // write contention from a fresh reset
        rstn = 0; cyc(); rstn = 1;
        for (int i = 0; i < NC; i++) set_req(i, 0, 1, 8'h05, 8'((i + 1) * 8'h11));
        for (int i = 0; i < NC; i++) wait_av("wr_order", 4'(1 << i));
        cyc();

        // fairness: core0 keeps requesting, core3 once
        set_req(0, 1, 0, 8'h01, 0); set_req(3, 1, 0, 8'h02, 0);
        got3 = 0;
        for (int k = 0; k < NC && !got3; k++) begin
            wait_any(got);
            if (got[3]) got3 = 1;
            rd_c[0] = 1;
        end
        chk("fair_core3", got3, 1'b1);
        wait_av("wrap_core0", 4'b0001);
        cyc();

        // read+write on one core is a write
        set_req(1, 1, 1, 8'h07, 8'h99);
        n = 0;
        do begin cyc(); n++; end while (mwr !== 1'b1 && n < 10);
        chk("rw_wdata", wdata, 8'h99);
        wait_av("rw_av", 4'b0010);
        chk("rw_memc_keep", memc[1*W +: W], 8'h00);
        cyc();

        // reset during WAIT
        set_req(2, 1, 0, 8'h3C, 0); set_req(3, 1, 0, 8'h40, 0);
        cyc(); cyc();
        rstn = 0; cyc(); rstn = 1;
        chk("rstw_av", av, '0);
        chk("rstw_memc", memc, '0);
        chk("rstw_rd", mrd, 1'b0);
        wait_av("rstw_next", 4'b0100);
        wait_av("rstw_core3", 4'b1000);
        cyc();

        // randomized traffic
        rand_mem = 1;
        for (int t = 0; t < 600; t++) begin
            cyc();
            for (int i = 0; i < NC; i++) begin
                if (!rd_c[i] && !wr_c[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        int op;
                        op = $urandom_range(0, 4);
                        set_req(i, op != 0, op <= 1,
                                $urandom_range(0, 1) ? 8'h10 : W'($urandom), W'($urandom));
                    end
                end else if ($urandom_range(0, 60) == 0) begin
                    rd_c[i] = 0; wr_c[i] = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
